// File: rtl/iter_div.sv
`timescale 1ns/1ps
// Iterative radix-2 restoring 32-bit divider, fixed 35-cycle occupancy, {quotient, remainder} result.
// Optional abort port div_flush is built when ITER_DIV_FLUSH_EN is defined.
module iter_div #(
  parameter int unsigned SIGNED = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
`ifdef ITER_DIV_FLUSH_EN
  input  logic                 div_flush,
`endif
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  input  logic [31:0]          s_axis_dividend_tdata,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [31:0]          s_axis_divisor_tdata,
  output logic                 m_axis_dout_tvalid,
  output logic [63:0]          m_axis_dout_tdata
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    quo;
  logic [W-1:0]    rem;
  logic [W-1:0]    dvs_mag;
  logic            sgn_a;
  logic            sgn_b;
  logic            dvs_zero;

  logic            flush;
  logic            accept;
  logic            in_sgn_a;
  logic            in_sgn_b;
  logic [W:0]      shifted;
  logic [W:0]      diff;
  logic [W-1:0]    q_fix;
  logic [W-1:0]    r_fix;

`ifdef ITER_DIV_FLUSH_EN
  assign flush = div_flush;
`else
  assign flush = 1'b0;
`endif

  assign s_axis_dividend_tready = (state == S_IDLE);
  assign s_axis_divisor_tready  = (state == S_IDLE);

  assign accept = (state == S_IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid && !flush;

  assign in_sgn_a = (SIGNED != 0) && s_axis_dividend_tdata[W-1];
  assign in_sgn_b = (SIGNED != 0) && s_axis_divisor_tdata[W-1];

  // One restoring step: shift in next dividend bit, trial-subtract the divisor magnitude
  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, dvs_mag};

  // With a zero divisor every trial succeeds, leaving rem = |dividend|; undo the magnitude to return the dividend
  assign q_fix = dvs_zero ? '1 : ((sgn_a ^ sgn_b) ? -quo : quo);
  assign r_fix = sgn_a ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state              <= S_IDLE;
      cnt                <= '0;
      quo                <= '0;
      rem                <= '0;
      dvs_mag            <= '0;
      sgn_a              <= 1'b0;
      sgn_b              <= 1'b0;
      dvs_zero           <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sgn_a    <= in_sgn_a;
            sgn_b    <= in_sgn_b;
            dvs_zero <= (s_axis_divisor_tdata == '0);
            quo      <= in_sgn_a ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
            dvs_mag  <= in_sgn_b ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
            rem      <= '0;
            cnt      <= '0;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (!diff[W]) begin
              rem <= diff[W-1:0];
              quo <= {quo[W-2:0], 1'b1};
            end else begin
              rem <= shifted[W-1:0];
              quo <= {quo[W-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            m_axis_dout_tdata  <= {q_fix, r_fix};
            m_axis_dout_tvalid <= 1'b1;
            state              <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
`timescale 1ns/1ps
// Directed bench for iter_div: signed and unsigned instances against an arithmetic reference model.
module tb_iter_div;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_flush = 1'b0;
  logic        a_v, b_v;
  logic [31:0] a_d, b_d;

  logic        ra_s, rb_s, v_s;
  logic [63:0] d_s;
  logic        ra_u, rb_u, v_u;
  logic [63:0] d_u;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_div #(.SIGNED(1)) u_s (
    .clk                    (clk),
    .resetn                 (resetn),
`ifdef ITER_DIV_FLUSH_EN
    .div_flush              (div_flush),
`endif
    .s_axis_dividend_tvalid (a_v),
    .s_axis_dividend_tready (ra_s),
    .s_axis_dividend_tdata  (a_d),
    .s_axis_divisor_tvalid  (b_v),
    .s_axis_divisor_tready  (rb_s),
    .s_axis_divisor_tdata   (b_d),
    .m_axis_dout_tvalid     (v_s),
    .m_axis_dout_tdata      (d_s)
  );

  iter_div #(.SIGNED(0)) u_u (
    .clk                    (clk),
    .resetn                 (resetn),
`ifdef ITER_DIV_FLUSH_EN
    .div_flush              (div_flush),
`endif
    .s_axis_dividend_tvalid (a_v),
    .s_axis_dividend_tready (ra_u),
    .s_axis_dividend_tdata  (a_d),
    .s_axis_divisor_tvalid  (b_v),
    .s_axis_divisor_tready  (rb_u),
    .s_axis_divisor_tdata   (b_d),
    .m_axis_dout_tvalid     (v_u),
    .m_axis_dout_tdata      (d_u)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  function automatic logic [63:0] ref_s(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = int'(a);
    sb = int'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {32'(q), 32'(r)};
  endfunction

  // Reference model: m_left counts cycles until the divider is free again
  int          m_left = 0;
  bit          armed  = 1'b0;
  logic [63:0] m_data_s, m_data_u, pend_s, pend_u;

  always @(posedge clk) begin
    armed = 1'b1;
    if (!resetn) begin
      m_left   = 0;
      m_data_s = '0;
      m_data_u = '0;
    end else if (div_flush && m_left > 0) begin
      m_left = 0;
    end else if (m_left == 0) begin
      if (a_v && b_v && !div_flush) begin
        m_left = 34;
        pend_s = ref_s(a_d, b_d);
        pend_u = ref_u(a_d, b_d);
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_data_s = pend_s;
        m_data_u = pend_u;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("tready_dividend_s", 64'(ra_s), 64'(m_left == 0));
      check("tready_divisor_s",  64'(rb_s), 64'(m_left == 0));
      check("tready_dividend_u", 64'(ra_u), 64'(m_left == 0));
      check("tready_divisor_u",  64'(rb_u), 64'(m_left == 0));
      check("tvalid_s", 64'(v_s), 64'(m_left == 1));
      check("tvalid_u", 64'(v_u), 64'(m_left == 1));
      check("tdata_s", d_s, m_data_s);
      check("tdata_u", d_u, m_data_u);
    end
  end

  // Entry and exit: 1 time unit after a rising edge
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] lit_s, input logic [63:0] lit_u);
    a_v = 1'b1;
    b_v = 1'b1;
    a_d = a;
    b_d = b;
    @(posedge clk); #1;
    a_v = 1'b0;
    b_v = 1'b0;
    a_d = $urandom;
    b_d = $urandom;
    repeat (33) begin @(posedge clk); #1; end
    check("lit_pulse_s", 64'(v_s), 64'd1);
    check("lit_pulse_u", 64'(v_u), 64'd1);
    check("lit_data_s", d_s, lit_s);
    check("lit_data_u", d_u, lit_u);
    @(posedge clk); #1;
    check("lit_ready_after", 64'(ra_s && ra_u), 64'd1);
  endtask

  int pulses;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    a_v = 1'b0;
    b_v = 1'b0;
    a_d = '0;
    b_d = '0;
    repeat (3) @(posedge clk);
    #1;
    check("lit_reset_data", d_s, 64'h0);
    check("lit_reset_valid", 64'(v_s), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, {32'h0000_000E, 32'h0000_0002}, {32'h0000_000E, 32'h0000_0002});
    run_op(32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, {32'h7FFF_FFFC, 32'h0000_0001});
    run_op(32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'h0000_0001}, {32'h0000_0000, 32'h0000_0007});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, {32'h0000_0000, 32'h8000_0000});
    run_op(32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFF9}, {32'hFFFF_FFFF, 32'hFFFF_FFF9});

    // Dividend valid alone must not be consumed
    a_v = 1'b1;
    a_d = 32'hFFFF_FFFF;
    b_d = 32'd2;
    repeat (10) begin
      @(posedge clk); #1;
      check("lit_single_valid_ready", 64'(ra_s && rb_s), 64'd1);
    end
    run_op(32'hFFFF_FFFF, 32'd2, {32'h0000_0000, 32'hFFFF_FFFF}, {32'h7FFF_FFFF, 32'h0000_0001});

    // Back-to-back with both valids held high
    a_v = 1'b1;
    b_v = 1'b1;
    a_d = 32'd1000;
    b_d = 32'd10;
    pulses = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (v_u) pulses++;
    end
    a_v = 1'b0;
    b_v = 1'b0;
    check("lit_b2b_pulses", 64'(pulses), 64'd2);
    check("lit_b2b_data", d_u, {32'd100, 32'd0});

    // Reset in the middle of an operation, released with both valids high
    a_v = 1'b1;
    b_v = 1'b1;
    a_d = 32'd100;
    b_d = 32'd7;
    @(posedge clk); #1;
    a_v = 1'b0;
    b_v = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    resetn = 1'b0;
    a_v = 1'b1;
    b_v = 1'b1;
    a_d = 32'd50;
    b_d = 32'd5;
    repeat (2) begin @(posedge clk); #1; end
    check("lit_midreset_data", d_s, 64'h0);
    check("lit_midreset_ready", 64'(ra_s), 64'd1);
    resetn = 1'b1;
    @(posedge clk); #1;
    a_v = 1'b0;
    b_v = 1'b0;
    repeat (33) begin @(posedge clk); #1; end
    check("lit_release_pulse", 64'(v_s), 64'd1);
    check("lit_release_data", d_s, {32'd10, 32'd0});
    @(posedge clk); #1;

`ifdef ITER_DIV_FLUSH_EN
    a_v = 1'b1;
    b_v = 1'b1;
    a_d = 32'd100;
    b_d = 32'd7;
    @(posedge clk); #1;
    a_v = 1'b0;
    b_v = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    div_flush = 1'b1;
    @(posedge clk); #1;
    div_flush = 1'b0;
    check("lit_flush_ready", 64'(ra_s), 64'd1);
    check("lit_flush_data", d_s, {32'd10, 32'd0});
    run_op(32'd100, 32'd7, {32'h0000_000E, 32'h0000_0002}, {32'h0000_000E, 32'h0000_0002});
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
